intr_aggregator: RTL and testbench

INTR_AGGREGATOR -- requirements
Module: intr_aggregator

---
 rtl/intr_aggregator.sv | 162 ++++++++++++++++
 tb/tb_intr_aggregator.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_aggregator.sv
// Purpose : latches interrupt source edges into a W1C status register and drives one interrupt line (level or pulse).
// Latency : raw_stat updates 1 cycle after a source edge; intr follows intr_stat by 1 cycle (level) or starts 1 cycle later (pulse).
// Backpr. : none; events that arrive during an active pulse collapse into a single queued follow-up pulse.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   src           level sources, a rising edge is an event
//   msk           1 = masked (except the NON_MASKABLE bits)
//   clr           write-1-to-clear strobe for raw_stat
//   init          clears the raw_stat bits selected by INIT_CLR
//   trig_type     0 = level interrupt, 1 = pulse interrupt
//   pulse_width   pulse length in cycles (0 behaves as 1)
//   raw_stat      latched raw status
//   intr_stat     raw_stat after masking (combinational)
//   intr          interrupt line
//   busy          pulse sequencer active
module intr_aggregator #(
  parameter int                  INTR_NUM            = 8,
  parameter int                  PULSE_WIDTH_BW      = 8,
  parameter int                  PULSE_WIDTH_DEFAULT = 10,
  parameter logic [INTR_NUM-1:0] NON_MASKABLE        = '0,
  parameter logic [INTR_NUM-1:0] INIT_CLR            = '1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INTR_NUM-1:0]       src,
  input  logic [INTR_NUM-1:0]       msk,
  input  logic [INTR_NUM-1:0]       clr,
  input  logic                      init,
  input  logic                      trig_type,
  input  logic [PULSE_WIDTH_BW-1:0] pulse_width,
  output logic [INTR_NUM-1:0]       raw_stat,
  output logic [INTR_NUM-1:0]       intr_stat,
  output logic                      intr,
  output logic                      busy
);

  // Parameter sanity checks, evaluated at elaboration only.
  if (INTR_NUM < 1 || INTR_NUM > 32) begin : g_bad_intr_num
    $error("intr_aggregator: INTR_NUM must be in 1..32");
  end
  if (PULSE_WIDTH_DEFAULT < 1 || PULSE_WIDTH_DEFAULT > (2**PULSE_WIDTH_BW) - 1) begin : g_bad_default
    $error("intr_aggregator: PULSE_WIDTH_DEFAULT must fit in PULSE_WIDTH_BW bits and be nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [PULSE_WIDTH_BW-1:0] CNT_ONE = {{(PULSE_WIDTH_BW-1){1'b0}}, 1'b1};

  logic [INTR_NUM-1:0]       r_src_d;
  logic                      r_armed;
  logic [INTR_NUM-1:0]       r_raw;
  logic [INTR_NUM-1:0]       r_intr_stat_d;
  state_t                    r_state;
  logic [PULSE_WIDTH_BW-1:0] r_cnt;
  logic                      r_pending;
  logic                      r_intr;

  logic [INTR_NUM-1:0]       w_event;
  logic [INTR_NUM-1:0]       w_clr;
  logic [INTR_NUM-1:0]       w_intr_stat;
  logic                      w_new_any;
  logic [PULSE_WIDTH_BW-1:0] w_width;
  state_t                    w_state_nxt;
  logic [PULSE_WIDTH_BW-1:0] w_cnt_nxt;
  logic                      w_pending_nxt;
  logic                      w_intr_nxt;

  // r_armed stays low for the first cycle after reset so that a source
  // already high at release is only absorbed into r_src_d, not reported.
  assign w_event     = src & ~r_src_d & {INTR_NUM{r_armed}};
  assign w_clr       = clr | ({INTR_NUM{init}} & INIT_CLR);
  assign w_intr_stat = r_raw & (~msk | NON_MASKABLE);
  // Unmasking an already-set bit also shows up here as a rising bit.
  assign w_new_any   = |(w_intr_stat & ~r_intr_stat_d);
  assign w_width     = (pulse_width == '0) ? CNT_ONE : pulse_width;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src_d       <= '0;
      r_armed       <= 1'b0;
      r_raw         <= '0;
      r_intr_stat_d <= '0;
    end else begin
      r_src_d       <= src;
      r_armed       <= 1'b1;
      // Set is applied after clear so a same-cycle event wins.
      r_raw         <= (r_raw & ~w_clr) | w_event;
      r_intr_stat_d <= w_intr_stat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_intr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
      r_intr    <= w_intr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    case (r_state)
      S_IDLE: begin
        // trig_type is only consulted here, so a running sequence
        // finishes in pulse mode even if software flips the mode.
        if (trig_type && w_new_any) begin
          w_state_nxt   = S_PULSE;
          w_cnt_nxt     = w_width;
          w_pending_nxt = 1'b0;
        end
      end
      S_PULSE: begin
        w_pending_nxt = r_pending | w_new_any;
        if (r_cnt <= CNT_ONE) begin
          w_state_nxt = w_pending_nxt ? S_GAP : S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_GAP: begin
        // Anything arriving during the gap is covered by this pulse.
        w_state_nxt   = S_PULSE;
        w_cnt_nxt     = w_width;
        w_pending_nxt = 1'b0;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_pending_nxt = 1'b0;
      end
    endcase
  end

  // intr is registered in both modes; in level mode it is the OR of
  // intr_stat delayed by one cycle.
  always_comb begin
    w_intr_nxt = 1'b0;
    if (w_state_nxt == S_PULSE) begin
      w_intr_nxt = 1'b1;
    end else if (w_state_nxt == S_IDLE && !trig_type) begin
      w_intr_nxt = |w_intr_stat;
    end
  end

  assign raw_stat  = r_raw;
  assign intr_stat = w_intr_stat;
  assign intr      = r_intr;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_intr_aggregator.sv
module tb_intr_aggregator;

  logic       clk;
  logic       rst;
  logic [7:0] src;
  logic [7:0] msk;
  logic [7:0] clr;
  logic       init;
  logic       trig_type;
  logic [7:0] pulse_width;
  logic [7:0] raw_stat;
  logic [7:0] intr_stat;
  logic       intr;
  logic       busy;

  int errors = 0;
  int checks = 0;

  intr_aggregator #(
    .INTR_NUM            (8),
    .PULSE_WIDTH_BW      (8),
    .PULSE_WIDTH_DEFAULT (10),
    .NON_MASKABLE        (8'h01),
    .INIT_CLR            (8'h0F)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src         (src),
    .msk         (msk),
    .clr         (clr),
    .init        (init),
    .trig_type   (trig_type),
    .pulse_width (pulse_width),
    .raw_stat    (raw_stat),
    .intr_stat   (intr_stat),
    .intr        (intr),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    clr = 8'hFF;
    tick();
    clr = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (raw_stat !== 8'h00 || intr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: raw=%h intr=%b busy=%b, want 00/0/0", raw_stat, intr, busy);
    end
    // Source held high across reset release must not register an event.
    src = 8'h80;
    rst = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (raw_stat !== 8'h00) begin
      errors++;
      $display("FAIL reset_src_high: raw=%h want 00", raw_stat);
    end
    src = 8'h00;
    tick();
    src = 8'h80;
    tick();
    checks++;
    if (raw_stat !== 8'h80) begin
      errors++;
      $display("FAIL reset_src_rearm: raw=%h want 80", raw_stat);
    end
    src = 8'h00;
    clear_all();
  endtask

  task automatic test_level();
    trig_type = 1'b0;
    msk       = 8'h00;
    src       = 8'h08;
    tick();
    src = 8'h00;
    checks++;
    if (raw_stat !== 8'h08 || intr !== 1'b0) begin
      errors++;
      $display("FAIL level_raw: raw=%h intr=%b want 08/0", raw_stat, intr);
    end
    tick();
    checks++;
    if (intr !== 1'b1) begin
      errors++;
      $display("FAIL level_intr_rise: intr=%b want 1", intr);
    end
    clr = 8'h08;
    tick();
    clr = 8'h00;
    checks++;
    if (raw_stat !== 8'h00 || intr !== 1'b1) begin
      errors++;
      $display("FAIL level_clr_first: raw=%h intr=%b want 00/1", raw_stat, intr);
    end
    tick();
    checks++;
    if (intr !== 1'b0) begin
      errors++;
      $display("FAIL level_intr_fall: intr=%b want 0", intr);
    end
    clear_all();
  endtask

  task automatic test_pulse();
    int hi = 0;
    int bz = 0;
    trig_type   = 1'b1;
    pulse_width = 8'd10;
    src         = 8'h01;
    tick();
    src = 8'h00;
    checks++;
    if (intr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pulse_latency: intr=%b busy=%b want 0/0", intr, busy);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (intr === 1'b1) hi++;
      if (busy === 1'b1) bz++;
    end
    checks++;
    if (hi != 10 || bz != 10) begin
      errors++;
      $display("FAIL pulse_width10: intr_cycles=%0d busy_cycles=%0d want 10/10", hi, bz);
    end
    clear_all();
  endtask

  task automatic test_queued();
    logic [11:0] got_i;
    logic [11:0] got_b;
    logic [11:0] exp_i;
    logic [11:0] exp_b;
    exp_i = 12'b0001_1110_1111;
    exp_b = 12'b0001_1111_1111;
    trig_type   = 1'b1;
    pulse_width = 8'd4;
    src         = 8'h02;
    tick();
    src = 8'h00;
    tick();
    got_i[0] = intr;
    got_b[0] = busy;
    src = 8'h04;
    tick();
    src = 8'h00;
    got_i[1] = intr;
    got_b[1] = busy;
    for (int i = 2; i < 12; i++) begin
      tick();
      got_i[i] = intr;
      got_b[i] = busy;
    end
    checks++;
    if (got_i !== exp_i) begin
      errors++;
      $display("FAIL queued_intr: pattern=%b want %b", got_i, exp_i);
    end
    checks++;
    if (got_b !== exp_b) begin
      errors++;
      $display("FAIL queued_busy: pattern=%b want %b", got_b, exp_b);
    end
    checks++;
    if (raw_stat !== 8'h06) begin
      errors++;
      $display("FAIL queued_raw: raw=%h want 06", raw_stat);
    end
    clear_all();
  endtask

  task automatic test_mask();
    trig_type   = 1'b1;
    pulse_width = 8'd2;
    msk         = 8'hFF;
    src         = 8'h21;
    tick();
    src = 8'h00;
    checks++;
    if (raw_stat !== 8'h21 || intr_stat !== 8'h01) begin
      errors++;
      $display("FAIL mask_stat: raw=%h intr_stat=%h want 21/01", raw_stat, intr_stat);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (busy !== 1'b0 || intr !== 1'b0) begin
      errors++;
      $display("FAIL mask_idle: busy=%b intr=%b want 0/0", busy, intr);
    end
    msk = 8'hDF;
    #1;
    checks++;
    if (intr_stat !== 8'h21) begin
      errors++;
      $display("FAIL unmask_comb: intr_stat=%h want 21", intr_stat);
    end
    tick();
    checks++;
    if (intr !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL unmask_pulse: intr=%b busy=%b want 1/1", intr, busy);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL unmask_done: busy=%b want 0", busy);
    end
    msk = 8'h00;
    clear_all();
  endtask

  task automatic test_set_wins_init();
    trig_type = 1'b0;
    src       = 8'h04;
    clr       = 8'h04;
    tick();
    src = 8'h00;
    clr = 8'h00;
    checks++;
    if (raw_stat !== 8'h04) begin
      errors++;
      $display("FAIL set_wins: raw=%h want 04", raw_stat);
    end
    src = 8'hFF;
    tick();
    src = 8'h00;
    checks++;
    if (raw_stat !== 8'hFF) begin
      errors++;
      $display("FAIL all_set: raw=%h want ff", raw_stat);
    end
    init = 1'b1;
    tick();
    init = 1'b0;
    checks++;
    if (raw_stat !== 8'hF0) begin
      errors++;
      $display("FAIL init_clr: raw=%h want f0", raw_stat);
    end
    clear_all();
  endtask

  task automatic test_pw_zero_and_rst();
    trig_type   = 1'b1;
    pulse_width = 8'd0;
    src         = 8'h01;
    tick();
    src = 8'h00;
    tick();
    checks++;
    if (intr !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pw0_high: intr=%b busy=%b want 1/1", intr, busy);
    end
    tick();
    checks++;
    if (intr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pw0_single: intr=%b busy=%b want 0/0", intr, busy);
    end
    clear_all();
    pulse_width = 8'd50;
    src         = 8'h02;
    tick();
    src = 8'h00;
    tick();
    tick();
    checks++;
    if (intr !== 1'b1 || busy !== 1'b1 || raw_stat !== 8'h02) begin
      errors++;
      $display("FAIL midpulse_pre: intr=%b busy=%b raw=%h want 1/1/02", intr, busy, raw_stat);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (intr !== 1'b0 || busy !== 1'b0 || raw_stat !== 8'h00) begin
      errors++;
      $display("FAIL async_rst: intr=%b busy=%b raw=%h want 0/0/00", intr, busy, raw_stat);
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_max_width();
    int hi = 0;
    trig_type   = 1'b1;
    pulse_width = 8'd255;
    src         = 8'h10;
    tick();
    src = 8'h00;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (intr === 1'b1) hi++;
    end
    checks++;
    if (hi != 255 || busy !== 1'b0) begin
      errors++;
      $display("FAIL max_width: intr_cycles=%0d busy=%b want 255/0", hi, busy);
    end
    clear_all();
  endtask

  initial begin
    rst         = 1'b1;
    src         = 8'h00;
    msk         = 8'h00;
    clr         = 8'h00;
    init        = 1'b0;
    trig_type   = 1'b0;
    pulse_width = 8'd10;
    test_reset();
    test_level();
    test_pulse();
    test_queued();
    test_mask();
    test_set_wins_init();
    test_pw_zero_and_rst();
    test_max_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
